// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the RV32 execute stage.
//
// Base RV32I arithmetic, logic, shift and compare ops complete in one cycle.
// The RV32M multiply/divide group is compiled in only when the macro
// ALU_MULDIV_EN is defined. It then iterates over XLEN cycles: a shift-add
// multiply, or a restoring divide on operand magnitudes with sign fix-up.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (aborts any operation in flight)
//   start   request, sampled only while busy=0
//   op      {m_sel, alt, funct3}
//   a, b    operands (latched at accept for M ops)
//   busy    iterative operation in progress
//   done    one-cycle pulse; result/zero/illegal valid
//   result  registered result, held until the next done
//   zero    registered (result == 0)
//   illegal registered; op encoding not supported
module alu_mc #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  logic            m_sel;
  logic            alt;
  logic [2:0]      f3;
  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  logic            base_ill;

  logic            fin_valid;
  logic [XLEN-1:0] fin_res;
  logic            fin_ill;

  assign m_sel  = op[4];
  assign alt    = op[3];
  assign f3     = op[2:0];
  assign accept = start & ~busy;
  assign shamt  = b[SHW-1:0];

  // Single-cycle base operations; unsupported alt encodings yield 0.
  always_comb begin
    base_res = '0;
    base_ill = 1'b0;
    if (alt && (f3 != 3'b000) && (f3 != 3'b101)) begin
      base_ill = 1'b1;
    end else begin
      case (f3)
        3'b000:  base_res = alt ? (a - b) : (a + b);
        3'b001:  base_res = a << shamt;
        3'b010:  base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        3'b011:  base_res = {{(XLEN-1){1'b0}}, (a < b)};
        3'b100:  base_res = a ^ b;
        3'b101:  base_res = alt ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
        3'b110:  base_res = a | b;
        default: base_res = a & b;
      endcase
    end
  end

`ifdef ALU_MULDIV_EN

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [SHW:0] LAST = (SHW+1)'(XLEN-1);

  state_t            state;
  state_t            state_next;
  logic [SHW:0]      cnt;
  // acc holds {product_hi, multiplier} for MUL, {remainder, quotient} for DIV.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              neg_q;
  logic              r_neg;
  logic              sel;
  logic              div0;

  logic              a_sgn;
  logic              b_sgn;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   mul_out;
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_hi;
  logic [XLEN-1:0]   div_lo;
  logic [XLEN-1:0]   div_q;
  logic [XLEN-1:0]   div_r;
  logic [XLEN-1:0]   div_out;

  assign busy = (state != IDLE);

  // Operand signedness per M encoding, then magnitudes for the unsigned core.
  always_comb begin
    if (f3[2]) begin
      a_sgn = ~f3[0];
      b_sgn = ~f3[0];
    end else begin
      a_sgn = (f3[1:0] == 2'b01) || (f3[1:0] == 2'b10);
      b_sgn = (f3[1:0] == 2'b01);
    end
    a_neg = a_sgn & a[XLEN-1];
    b_neg = b_sgn & b[XLEN-1];
    a_mag = a_neg ? (-a) : a;
    b_mag = b_neg ? (-b) : b;
  end

  // One iteration of each datapath, plus the final sign/select stage that is
  // folded into the last iteration so done lands in cycle XLEN+1.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_step = {mul_sum, acc[XLEN-1:1]};
    mul_prod = neg_q ? (-mul_step) : mul_step;
    mul_out  = sel ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];

    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_ge   = ~div_diff[XLEN];
    div_hi   = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    div_lo   = {acc[XLEN-2:0], div_ge};
    // Divide by zero leaves the dividend magnitude as remainder, so only the
    // quotient needs overriding; signed overflow falls out of the negation.
    div_q    = div0 ? '1 : (neg_q ? (-div_lo) : div_lo);
    div_r    = r_neg ? (-div_hi) : div_hi;
    div_out  = sel ? div_r : div_q;
  end

  always_comb begin
    state_next = state;
    fin_valid  = 1'b0;
    fin_res    = m_sel ? '0 : base_res;
    fin_ill    = base_ill | m_sel;
    case (state)
      IDLE: begin
        if (accept) begin
          if (m_sel && !alt) begin
            state_next = f3[2] ? DIV : MUL;
          end else begin
            fin_valid = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt == LAST) begin
          state_next = IDLE;
          fin_valid  = 1'b1;
          fin_res    = mul_out;
          fin_ill    = 1'b0;
        end
      end
      DIV: begin
        if (cnt == LAST) begin
          state_next = IDLE;
          fin_valid  = 1'b1;
          fin_res    = div_out;
          fin_ill    = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      neg_q <= 1'b0;
      r_neg <= 1'b0;
      sel   <= 1'b0;
      div0  <= 1'b0;
    end else if (state == IDLE) begin
      if (accept && m_sel && !alt) begin
        cnt   <= '0;
        acc   <= {{XLEN{1'b0}}, (f3[2] ? a_mag : b_mag)};
        opnd  <= f3[2] ? b_mag : a_mag;
        neg_q <= a_neg ^ b_neg;
        r_neg <= a_neg;
        sel   <= f3[2] ? f3[1] : (f3[1:0] != 2'b00);
        div0  <= (b == '0);
      end
    end else begin
      cnt <= cnt + 1'b1;
      acc <= (state == MUL) ? mul_step : {div_hi, div_lo};
    end
  end

`else

  assign busy = 1'b0;

  always_comb begin
    fin_valid = accept;
    fin_res   = m_sel ? '0 : base_res;
    fin_ill   = base_ill | m_sel;
  end

`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else begin
      done <= fin_valid;
      if (fin_valid) begin
        result  <= fin_res;
        zero    <= (fin_res == '0);
        illegal <= fin_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int total = 0;
  int bad   = 0;

  alu_mc #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vt[$];

  // Issue one op in the current cycle (cycle 0) and wait for done.
  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic bz);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 5'($urandom);
    lat = 1;
    bz  = busy;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      bz = bz | busy;
    end
  endtask

  initial begin
    int   lat;
    logic bz;
    vec_t v;
    logic [31:0] held;

    vt.push_back('{"add",    5'b00000, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1});
    vt.push_back('{"sub",    5'b01000, 32'd3,        32'd3,        32'd0,        1'b1, 1'b0, 1});
    vt.push_back('{"sll",    5'b00001, 32'h1,        32'h21,       32'h2,        1'b0, 1'b0, 1});
    vt.push_back('{"slt",    5'b00010, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1});
    vt.push_back('{"sltu",   5'b00011, 32'h1,        32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 1});
    vt.push_back('{"sltu0",  5'b00011, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1});
    vt.push_back('{"xor",    5'b00100, 32'hF0F0,     32'hFF00,     32'h0FF0,     1'b0, 1'b0, 1});
    vt.push_back('{"srl",    5'b00101, 32'h80000000, 32'h24,       32'h08000000, 1'b0, 1'b0, 1});
    vt.push_back('{"sra",    5'b01101, 32'h80000000, 32'h24,       32'hF8000000, 1'b0, 1'b0, 1});
    vt.push_back('{"or",     5'b00110, 32'hA0,       32'h05,       32'hA5,       1'b0, 1'b0, 1});
    vt.push_back('{"and",    5'b00111, 32'hF0,       32'h3C,       32'h30,       1'b0, 1'b0, 1});
    vt.push_back('{"ill100", 5'b01100, 32'h12,       32'h34,       32'h0,        1'b1, 1'b1, 1});
    vt.push_back('{"ill001", 5'b01001, 32'h12,       32'h1,        32'h0,        1'b1, 1'b1, 1});
    vt.push_back('{"add2",   5'b00000, 32'h1,        32'h2,        32'h3,        1'b0, 1'b0, 1});
    vt.push_back('{"mulh",   5'b10001, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 1'b0, 1'b0, 33});
    vt.push_back('{"mulhu",  5'b10011, 32'hFFFFFFFF, 32'h2,        32'h1,        1'b0, 1'b0, 33});
    vt.push_back('{"mul",    5'b10000, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 1'b0, 1'b0, 33});
    vt.push_back('{"mulhsu", 5'b10010, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 1'b0, 1'b0, 33});
    vt.push_back('{"mul34",  5'b10000, 32'd3,        32'd4,        32'd12,       1'b0, 1'b0, 33});
    vt.push_back('{"div",    5'b10100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b0, 1'b0, 33});
    vt.push_back('{"rem",    5'b10110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 1'b0, 1'b0, 33});
    vt.push_back('{"divu0",  5'b10101, 32'd10,       32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 33});
    vt.push_back('{"remu0",  5'b10111, 32'd10,       32'd0,        32'd10,       1'b0, 1'b0, 33});
    vt.push_back('{"divovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 33});
    vt.push_back('{"removf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 33});
    vt.push_back('{"divs0",  5'b10100, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 33});
    vt.push_back('{"rems0",  5'b10110, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1'b0, 1'b0, 33});
    vt.push_back('{"divu",   5'b10101, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 33});
    vt.push_back('{"mill",   5'b11000, 32'd3,        32'd4,        32'h0,        1'b1, 1'b1, 1});

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_result",  result,       32'd0);
    chk("rst_zero",    32'(zero),    32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back base ops: done in cycles 1 and 2, result held afterwards.
    start = 1'b1; op = 5'b00000; a = 32'd5; b = 32'd7;
    @(posedge clk); #1;
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_res1",  result,    32'd12);
    chk("b2b_zero1", 32'(zero), 32'd0);
    op = 5'b01000; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_res2",  result,    32'd0);
    chk("b2b_zero2", 32'(zero), 32'd1);
    start = 1'b0; op = 5'b00000; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    chk("b2b_done3", 32'(done), 32'd0);
    chk("b2b_hold",  result,    32'd0);

    foreach (vt[i]) begin
      v = vt[i];
`ifndef ALU_MULDIV_EN
      if (v.op[4]) begin
        v.res = 32'h0; v.z = 1'b1; v.ill = 1'b1; v.lat = 1;
      end
`endif
      run_op(v.op, v.a, v.b, lat, bz);
      chk({v.name, "_lat"},  32'(lat),     32'(v.lat));
      chk({v.name, "_res"},  result,       v.res);
      chk({v.name, "_zero"}, 32'(zero),    32'(v.z));
      chk({v.name, "_ill"},  32'(illegal), 32'(v.ill));
      chk({v.name, "_busy"}, 32'(bz),      32'(v.lat > 1));
    end

    held = result;
    @(posedge clk); #1;
    chk("post_done", 32'(done), 32'd0);
    chk("post_hold", result,    held);

`ifdef ALU_MULDIV_EN
    // Abort: DIVU accepted in cycle 0, ignored start in cycle 5, reset in cycle 10.
    run_op(5'b00000, 32'd40, 32'd2, lat, bz);
    chk("pre_abort_res", result, 32'd42);
    start = 1'b1; op = 5'b10101; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 5'b00000; a = '0; b = '0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 5'b00000; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_done", 32'(done), 32'd0);
    chk("ign_busy", 32'(busy), 32'd1);
    chk("ign_res",  result,    32'd42);
    repeat (4) @(posedge clk);
    #1;
    chk("c10_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy),    32'd0);
    chk("abort_done", 32'(done),    32'd0);
    chk("abort_res",  result,       32'd0);
    chk("abort_zero", 32'(zero),    32'd1);
    chk("abort_ill",  32'(illegal), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bz = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      bz = bz | done | busy;
    end
    chk("abort_no_done", 32'(bz), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
